// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage driving a one-cycle-latency word memory,
// buffering {pc, insn} pairs in a 2-entry skid FIFO for decode.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h80020000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic        mem_write,
  input  logic [31:0] mem_data_in,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  output logic        fetch_fault
);

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] insn_q, insn_d, insn_pc_q, insn_pc_d;
  logic [31:0] slot1_insn_q, slot1_insn_d, slot1_pc_q, slot1_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic        pop, push, issue, misaligned;
  logic [2:0]  occupancy;

  always_comb begin
    pop        = valid_q && !stall;
    push       = inflight_q && !redirect;
    misaligned = redirect && (redirect_pc[1:0] != 2'b00);
    // Entries that will be held after this cycle, counting the one in flight.
    occupancy  = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue      = (state_q == RUN) && !redirect && (occupancy < DEPTH);

    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = inflight_q;
    count_d       = count_q;
    insn_d        = insn_q;
    insn_pc_d     = insn_pc_q;
    slot1_insn_d  = slot1_insn_q;
    slot1_pc_d    = slot1_pc_q;
    state_d       = state_q;

    if (redirect) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      pc_d       = {redirect_pc[31:2], 2'b00};
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            insn_d    = mem_data_in;
            insn_pc_d = inflight_pc_q;
          end else begin
            slot1_insn_d = mem_data_in;
            slot1_pc_d   = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            insn_d    = slot1_insn_q;
            insn_pc_d = slot1_pc_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            insn_d       = slot1_insn_q;
            insn_pc_d    = slot1_pc_q;
            slot1_insn_d = mem_data_in;
            slot1_pc_d   = inflight_pc_q;
          end else begin
            insn_d    = mem_data_in;
            insn_pc_d = inflight_pc_q;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (misaligned) begin
      state_d = FAULT;
    end else if (redirect && (state_q == FAULT)) begin
      state_d = enable ? RUN : IDLE;
    end

    valid_d = (count_d != 2'd0);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= PC_RESET;
      inflight_pc_q <= 32'd0;
      inflight_q    <= 1'b0;
      count_q       <= 2'd0;
      insn_q        <= 32'd0;
      insn_pc_q     <= 32'd0;
      slot1_insn_q  <= 32'd0;
      slot1_pc_q    <= 32'd0;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      insn_q        <= insn_d;
      insn_pc_q     <= insn_pc_d;
      slot1_insn_q  <= slot1_insn_d;
      slot1_pc_q    <= slot1_pc_d;
      valid_q       <= valid_d;
      fault_q       <= fault_d;
    end
  end

  assign mem_address     = pc_q;
  assign mem_access_size = 2'b10;
  assign mem_write       = 1'b0;
  assign insn            = insn_q;
  assign insn_pc         = insn_pc_q;
  assign insn_valid      = valid_q;
  assign fetch_fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven per-cycle vectors plus hand-written reset sequences.
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_write;
  logic [31:0] mem_data_in = 32'd0;
  logic [31:0] insn, insn_pc;
  logic        insn_valid, fetch_fault;

  int passed = 0;
  int total  = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_address(mem_address), .mem_access_size(mem_access_size),
    .mem_write(mem_write), .mem_data_in(mem_data_in),
    .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h80020000: return 32'h98765432;
      32'h80020004: return 32'h11112222;
      32'h80020008: return 32'h0000AAAA;
      default:      return ~a;
    endcase
  endfunction

  // Memory with one cycle of read latency.
  always @(posedge clk) mem_data_in <= memf(mem_address);

  typedef struct {
    logic        en, st, rd;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ipc;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic st, input logic rd, input logic [31:0] rpc,
                     input logic [31:0] addr, input logic v, input logic [31:0] ipc, input logic f);
    vec_t x;
    x.en = en; x.st = st; x.rd = rd; x.rpc = rpc;
    x.addr = addr; x.v = v; x.ipc = ipc; x.f = f;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  initial begin
    int waited;
    // en st rd rpc | addr v ipc f
    add(1,0,0,0,            32'h80020000,0,0,0);            // c0
    add(1,0,0,0,            32'h80020000,0,0,0);
    add(1,0,0,0,            32'h80020004,0,0,0);
    add(1,0,0,0,            32'h80020008,1,32'h80020000,0);
    add(1,1,0,0,            32'h8002000C,1,32'h80020004,0); // c4 stall
    add(1,1,0,0,            32'h8002000C,1,32'h80020004,0);
    add(1,1,0,0,            32'h8002000C,1,32'h80020004,0);
    add(1,1,0,0,            32'h8002000C,1,32'h80020004,0);
    add(1,1,0,0,            32'h8002000C,1,32'h80020004,0);
    add(1,0,0,0,            32'h8002000C,1,32'h80020004,0); // c9
    add(1,0,0,0,            32'h80020010,1,32'h80020008,0);
    add(1,0,0,0,            32'h80020014,1,32'h8002000C,0);
    add(1,1,1,32'h80020100, 32'h80020018,1,32'h80020010,0); // c12 redirect
    add(1,0,0,0,            32'h80020100,0,0,0);
    add(1,0,0,0,            32'h80020104,0,0,0);
    add(1,0,0,0,            32'h80020108,1,32'h80020100,0);
    add(1,0,1,32'h80020102, 32'h8002010C,1,32'h80020104,0); // c16 misaligned
    add(1,0,0,0,            32'h80020100,0,0,1);
    add(1,0,1,32'h80020200, 32'h80020100,0,0,1);
    add(1,0,0,0,            32'h80020200,0,0,0);
    add(1,0,0,0,            32'h80020204,0,0,0);
    add(1,0,0,0,            32'h80020208,1,32'h80020200,0);
    add(1,0,1,32'hFFFFFFF8, 32'h8002020C,1,32'h80020204,0); // c22 wrap
    add(1,0,0,0,            32'hFFFFFFF8,0,0,0);
    add(1,0,0,0,            32'hFFFFFFFC,0,0,0);
    add(1,0,0,0,            32'h00000000,1,32'hFFFFFFF8,0);
    add(1,0,0,0,            32'h00000004,1,32'hFFFFFFFC,0);
    add(0,0,0,0,            32'h00000008,1,32'h00000000,0); // c27 disable
    add(0,0,0,0,            32'h0000000C,1,32'h00000004,0);
    add(0,0,0,0,            32'h0000000C,1,32'h00000008,0);
    add(0,0,0,0,            32'h0000000C,0,0,0);

    repeat (2) @(negedge clk);
    chk("reset addr",  mem_address, 32'h80020000);
    chk("reset valid", {31'd0, insn_valid}, 32'd0);
    chk("reset insn",  insn, 32'd0);
    chk("reset ipc",   insn_pc, 32'd0);
    chk("reset fault", {31'd0, fetch_fault}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      enable = vecs[i].en; stall = vecs[i].st;
      redirect = vecs[i].rd; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("c%0d addr", i),  mem_address, vecs[i].addr);
      chk($sformatf("c%0d valid", i), {31'd0, insn_valid}, {31'd0, vecs[i].v});
      chk($sformatf("c%0d fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].f});
      chk($sformatf("c%0d wr/sz", i), {29'd0, mem_write, mem_access_size}, 32'd2);
      if (vecs[i].v) begin
        chk($sformatf("c%0d ipc", i),  insn_pc, vecs[i].ipc);
        chk($sformatf("c%0d insn", i), insn, memf(vecs[i].ipc));
      end
    end

    // Fill the FIFO under stall, then reset asynchronously mid-cycle.
    @(negedge clk);
    enable = 1'b1; stall = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (5) @(negedge clk);
    #1;
    chk("full valid", {31'd0, insn_valid}, 32'd1);
    chk("full ipc",   insn_pc, 32'h0000000C);
    chk("full insn",  insn, memf(32'h0000000C));
    chk("full addr",  mem_address, 32'h00000014);
    #2 rst = 1'b1;
    #1;
    chk("async valid", {31'd0, insn_valid}, 32'd0);
    chk("async insn",  insn, 32'd0);
    chk("async ipc",   insn_pc, 32'd0);
    chk("async addr",  mem_address, 32'h80020000);
    chk("async fault", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    waited = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      if (insn_valid) begin
        waited = k;
        break;
      end
    end
    chk("post-reset latency", waited, 3);
    chk("post-reset ipc",  insn_pc, 32'h80020000);
    chk("post-reset insn", insn, 32'h98765432);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
